// File: rtl/ram_seg7_scan.sv
// Scans four RAM bytes as 8 hex digits on a multiplexed 7-segment display, with dark guard gaps between digits.
// Latency: outputs are registered one cycle behind the FSM; the input bytes are snapshotted once per frame.
module ram_seg7_scan #(
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 2,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ram20,
    input  logic [7:0] ram21,
    input  logic [7:0] ram22,
    input  logic [7:0] ram23,
    input  logic [3:0] dp_en,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] dig,
    output logic       frame
);

    typedef enum logic [1:0] {S_LOAD, S_GUARD, S_SHOW} state_t;

    localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [31:0] sh_ram;
    logic [3:0]  sh_dp;

    logic [7:0] cur_byte;
    logic [3:0] nib;
    logic [6:0] seg_hi;
    logic       lit;

    always_comb begin
        cur_byte = sh_ram[{idx[2:1], 3'b000} +: 8];
        nib      = idx[0] ? cur_byte[7:4] : cur_byte[3:0];
        lit      = (state == S_SHOW) && !blank;
        case (nib)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_LOAD;
            cnt    <= 16'd0;
            idx    <= 3'd0;
            sh_ram <= 32'd0;
            sh_dp  <= 4'd0;
            seg    <= {7{SEG_ACT_LOW}};
            dp     <= SEG_ACT_LOW;
            dig    <= {8{DIG_ACT_LOW}};
            frame  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    sh_ram <= {ram23, ram22, ram21, ram20};
                    sh_dp  <= dp_en;
                    cnt    <= 16'd0;
                    state  <= S_GUARD;
                end
                S_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= 16'd0;
                        state <= S_SHOW;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= 16'd0;
                        idx <= idx + 3'd1;
                        // idx wraps 7 -> 0 naturally at the end of the frame
                        state <= (idx == 3'd7) ? S_LOAD : S_GUARD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase

            seg   <= (lit ? seg_hi : 7'h00) ^ {7{SEG_ACT_LOW}};
            dp    <= (lit && idx[0] && sh_dp[idx[2:1]]) ^ SEG_ACT_LOW;
            dig   <= (lit ? (8'h01 << idx) : 8'h00) ^ {8{DIG_ACT_LOW}};
            frame <= (state == S_LOAD);
        end
    end

endmodule

// File: tb/tb_ram_seg7_scan.sv
// Random and directed stimulus against a frame-phase reference model of the scanned display.
module tb_ram_seg7_scan;

    localparam int S  = 4;
    localparam int G  = 1;
    localparam int F  = 1 + 8 * (G + S);
    localparam bit SAL = 1'b1;
    localparam bit DAL = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ram20 = 8'hFF, ram21 = 8'hFF, ram22 = 8'hFF, ram23 = 8'hFF;
    logic [3:0] dp_en = 4'h0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] dig;
    logic       frame;

    ram_seg7_scan #(.SCAN_DIV(S), .GUARD(G), .SEG_ACT_LOW(SAL), .DIG_ACT_LOW(DAL)) dut (
        .clk(clk), .rst(rst),
        .ram20(ram20), .ram21(ram21), .ram22(ram22), .ram23(ram23),
        .dp_en(dp_en), .blank(blank),
        .seg(seg), .dp(dp), .dig(dig), .frame(frame)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state: position within the frame and the snapshot it uses
    int        ph = 0;
    bit [7:0]  snap [4];
    bit [3:0]  sdp = 4'h0;
    bit [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int        cyc = 0;
    int        last_frame = 0;
    bit        have_last = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        int  q, d, nib;
        bit  show, lit;
        bit [6:0] e_seg;
        bit       e_dp, e_frame;
        bit [7:0] e_dig;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            e_seg = {7{SAL}}; e_dp = SAL; e_dig = {8{DAL}}; e_frame = 1'b0;
            ph = 0;
            foreach (snap[k]) snap[k] = 8'h00;
            sdp = 4'h0;
            have_last = 1'b0;
        end else begin
            show = 1'b0;
            d = 0;
            if (ph == 0) begin
                snap[0] = ram20; snap[1] = ram21; snap[2] = ram22; snap[3] = ram23;
                sdp = dp_en;
            end else begin
                q = ph - 1;
                d = q / (G + S);
                show = (q % (G + S)) >= G;
            end
            lit = show && !blank;
            nib = (d % 2 == 1) ? int'(snap[d / 2] >> 4) : int'(snap[d / 2] & 8'h0F);
            e_seg   = (lit ? hex_tab[nib] : 7'h00) ^ {7{SAL}};
            e_dp    = (lit && (d % 2 == 1) && sdp[d / 2]) ^ SAL;
            e_dig   = (lit ? (8'h01 << d) : 8'h00) ^ {8{DAL}};
            e_frame = (ph == 0);
            ph = (ph + 1) % F;
        end
        #1;
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("dig", dig, e_dig);
        chk("frame", frame, e_frame);
        if (frame === 1'b1) begin
            if (have_last) chk("frame_gap", cyc - last_frame, F);
            last_frame = cyc;
            have_last = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // step until the model is at the given frame phase (bounded by one frame)
    task automatic seek(input int target);
        int guard_cnt = 0;
        while (ph != target && guard_cnt <= F) begin
            step();
            guard_cnt++;
        end
        if (ph != target) chk("seek_timeout", ph, target);
    endtask

    initial begin
        // reset held for 5 cycles with all-ones RAM
        rst = 1'b0;
        run(5);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dig", dig, 8'hFF);

        ram20 = 8'h12; ram21 = 8'h34; ram22 = 8'h56; ram23 = 8'h78; dp_en = 4'h0;
        rst = 1'b1;
        step();
        chk("rel_frame", frame, 1);
        step();
        chk("rel_guard_dig", dig, 8'hFF);
        step();
        chk("d0_dig", dig, 8'hFE);
        chk("d0_seg", seg, 7'h24);

        // change a byte while digit 1 is lit; it must wait for the next frame
        run(5);
        chk("d1_dig", dig, 8'hFD);
        ram21 = 8'hAB;
        run(F * 2);

        dp_en = 4'b0010;
        run(F * 3);

        // blank across digit 3, released 6 cycles later
        seek(1 + 3 * (G + S) + G + 1);
        blank = 1'b1;
        step();
        chk("blank_dig", dig, 8'hFF);
        run(5);
        blank = 1'b0;
        run(F);

        // reset during digit 5 after changing byte 0
        ram20 = 8'h9C;
        seek(1 + 5 * (G + S) + G + 2);
        rst = 1'b0;
        step();
        chk("midrst_dig", dig, 8'hFF);
        rst = 1'b1;
        step();
        chk("midrst_frame", frame, 1);
        step();
        step();
        chk("midrst_d0_seg", seg, 7'h46);
        run(F);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(3))
                    0: ram20 = 8'($urandom);
                    1: ram21 = 8'($urandom);
                    2: ram22 = 8'($urandom);
                    default: ram23 = 8'($urandom);
                endcase
            end
            if ($urandom_range(29) == 0) dp_en = 4'($urandom);
            if ($urandom_range(14) == 0) blank = ~blank;
            rst = ($urandom_range(299) != 0);
            step();
        end
        rst = 1'b1;
        blank = 1'b0;
        run(F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_seg7_scan.md
Name: ram_seg7_scan

Overview:
- Display stage directly downstream of the 4-byte data RAM.
- Consumes the four RAM mirror bytes (ram20..ram23) and drives an 8-digit multiplexed 7-segment display in hex, two digits per byte.
- Snapshots all four bytes once per frame so a frame never shows a mix of old and new data.
- Inserts a ghost-guard interval with all digits dark between digits.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is lit (SHOW length); legal range 2..65536.
- GUARD, 2, clock cycles all digits are dark before each digit (GUARD length); legal range 1..255.
- SEG_ACT_LOW, 1, 1 = segment and dp pins active-low; 0 = active-high.
- DIG_ACT_LOW, 1, 1 = digit-enable pins active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- ram20  in  8  RAM byte 0.
- ram21  in  8  RAM byte 1.
- ram22  in  8  RAM byte 2.
- ram23  in  8  RAM byte 3.
- dp_en  in  4  dp_en[k]=1 lights dp on the high-nibble digit of byte k.
- blank  in  1  1 = force display dark; scanning continues.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- dig  out  8  digit enables; dig[i] selects digit i.
- frame  out  1  one-cycle pulse per frame.

Behaviour:
- Reset/clock: one clock, clk. rst is synchronous active-low and is sampled only on the rising clk edge; no asynchronous path.
- Reset values (rst=0 at an edge):
  - state=LOAD, idx=0, counter=0, shadow bytes=8'h00.
  - Outputs at inactive levels: seg all off, dp off, dig all off, frame=0. With default params that is seg=7'h7F, dp=1, dig=8'hFF.
- Reset mid-operation: identical to power-up. The partial frame is abandoned and the first frame after release starts at digit 0 with a new snapshot.
- FSM states: LOAD, GUARD, SHOW.
  - LOAD: lasts 1 cycle. Copies ram20..ram23 and dp_en into shadow registers. Next state GUARD, counter=0.
  - GUARD: counter counts 0..GUARD-1. At GUARD-1, next state SHOW, counter=0.
  - SHOW: counter counts 0..SCAN_DIV-1. At SCAN_DIV-1:
    - idx==7: next state LOAD, idx=0.
    - otherwise: idx=idx+1, next state GUARD.
- Frame length: 1 + 8*(GUARD+SCAN_DIV) cycles. Digit 0 is preceded by LOAD and GUARD; digits 1..7 by GUARD only.
- Digit mapping: digit i shows shadow byte i/2. Even i shows nibble [3:0]; odd i shows nibble [7:4]. Digit 0 is ram20 low nibble; digit 7 is ram23 high nibble.
- Hex decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- dp is lit only in SHOW, on odd i, when shadow dp_en[i/2]=1.
- Dark conditions: state LOAD or GUARD, or blank=1 → all digits off, seg off, dp off. In SHOW with blank=0, exactly one dig bit is active (one-hot at idx).
- blank does not stall or reset the FSM, counter or idx.
- Polarity: pins = internal active-high value XOR the polarity parameter (SEG_ACT_LOW for seg and dp, DIG_ACT_LOW for dig).
- Latency: all outputs are registered and reflect the FSM state, idx, shadow and blank of the previous cycle (1-cycle latency). frame=1 in exactly the cycle after the LOAD cycle.
- Snapshot: ram20..ram23 and dp_en changes after a LOAD are ignored until the next LOAD. A value that changes in the LOAD cycle itself is captured as sampled at that edge.
- Counter width: 16 bits; idx 3 bits; neither counter is free-running outside the FSM rules.

Test Plan (SCAN_DIV=4, GUARD=1, active-low defaults; frame = 41 cycles):
- Reset: ram20..23=8'hFF, hold rst=0 for 5 cycles → each cycle seg=7'h7F, dp=1, dig=8'hFF, frame=0. Release → frame=1 in the 2nd cycle after release.
- Scan order: ram20=8'h12, ram21=8'h34, ram22=8'h56, ram23=8'h78, dp_en=0 → digits 0..7 show 2,1,4,3,6,5,8,7. Digit 0: dig=8'hFE, seg=7'h24 for 4 cycles, each digit preceded by 1 dark cycle.
- Snapshot: change ram21 to 8'hAB while digit 1 is lit → digits 2,3 still show 4,3 in this frame; next frame shows B,A (seg=7'h03, 7'h08).
- Frame period / dp: free-run 3 frames with dp_en=4'b0010 → frame pulses exactly 41 cycles apart, 1 cycle wide; dp=0 only while digit 3 is lit.
- Blank: assert blank=1 during digit 3, release 6 cycles later → dig=8'hFF from the next cycle. On release, display resumes at the digit implied by uninterrupted timing; the frame pulse position is unchanged.
- Reset mid-frame: rst=0 for 1 cycle while digit 5 is lit, with ram20 changed to 8'h9C beforehand → outputs inactive next cycle; after release, LOAD runs, then digit 0 shows C (seg=7'h46), digit 1 shows 9.
